// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
//  Module   : pio_in_edge_irq
//  Purpose  : Avalon-MM input PIO for player controls. Synchronises and
//             optionally debounces WIDTH raw inputs, latches per-bit edge
//             events and raises a maskable level interrupt.
//  Ports    : clk, reset_n          - clock, asynchronous active-low reset
//             address[1:0]          - 0 data, 1 reserved, 2 irqmask,
//                                     3 edgecapture
//             chipselect, write_n   - write qualifies on cs=1 and write_n=0
//             writedata[31:0]       - write data
//             readdata[31:0]        - registered read data (1-cycle latency)
//             in_port[WIDTH-1:0]    - raw asynchronous inputs
//             irq                   - active-high level interrupt
//  Revision : 1.0 - initial release
// ============================================================================
module pio_in_edge_irq #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_RSVD  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;

    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: a bit's stable level follows the synchronised level only
    // after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;

    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
        always_comb begin
            stable_d = sync_w;
        end
    end else begin : g_debounce
        localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [WIDTH-1:0] bit_next;

        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             bit_d;

            // Any agreement between sync and stable restarts the count,
            // so a short glitch never accumulates towards acceptance.
            always_comb begin
                cnt_d = '0;
                bit_d = stable_q[b];
                if (sync_w[b] != stable_q[b]) begin
                    if (cnt_q == CNT_LAST) begin
                        bit_d = sync_w[b];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign bit_next[b] = bit_d;
        end

        always_comb begin
            stable_d = bit_next;
        end
    end

    // ------------------------------------------------------------------
    // Edge detection on the clean level
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] stable_dly_q;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] ev_w;

    assign rise_w = stable_q & ~stable_dly_q;
    assign fall_w = ~stable_q & stable_dly_q;

    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign ev_w = rise_w;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign ev_w = fall_w;
    end else begin : g_edge_any
        assign ev_w = rise_w | fall_w;
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic             wr_en_w;
    logic [WIDTH-1:0] clr_w;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             unused_wdata;

    assign wr_en_w      = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        clr_w = '0;
        if (wr_en_w && address == ADDR_EDGE) begin
            clr_w = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        // New events are OR-ed in after the clear so a coincident event wins.
        edgecap_d = (edgecap_q & ~clr_w) | ev_w;
        irqmask_d = irqmask_q;
        if (wr_en_w && address == ADDR_MASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(stable_q);
            ADDR_RSVD: readdata_d = '0;
            ADDR_MASK: readdata_d = 32'(irqmask_q);
            ADDR_EDGE: readdata_d = 32'(edgecap_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            edgecap_q    <= '0;
            irqmask_q    <= '0;
            readdata_q   <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            edgecap_q    <= edgecap_d;
            irqmask_q    <= irqmask_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_in_edge_irq
//  Purpose  : Self-checking bench for pio_in_edge_irq. Three instances share
//             the bus: A (2 bits, no debounce, rising), B (2 bits, debounce 4,
//             rising), C (32 bits, no debounce, any edge).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pio_in_edge_irq;

    localparam int SYNC = 2;

    function automatic int f_w(int i);
        return (i == 2) ? 32 : 2;
    endfunction
    function automatic int f_deb(int i);
        return (i == 1) ? 4 : 0;
    endfunction
    function automatic int f_et(int i);
        return (i == 2) ? 2 : 0;
    endfunction
    function automatic logic [31:0] f_wm(int i);
        return (f_w(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << f_w(i)) - 32'd1);
    endfunction

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] pin [3];
    logic [31:0] rd [3];
    logic [2:0]  irqv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
        .in_port(pin[0][1:0]), .irq(irqv[0]));

    pio_in_edge_irq #(.WIDTH(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
        .in_port(pin[1][1:0]), .irq(irqv[1]));

    pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
        .in_port(pin[2]), .irq(irqv[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: histories of sampled inputs and synchronised
    // values; the clean level accepts a new value once the last DEB
    // synchronised samples all disagreed with it.
    // ------------------------------------------------------------------
    logic [31:0] m_hin   [3][4];
    logic [31:0] m_hsync [3][8];
    logic [31:0] m_stable [3];
    logic [31:0] m_prev   [3];
    logic [31:0] m_ecap   [3];
    logic [31:0] m_mask   [3];
    logic [31:0] m_rd     [3];

    function automatic logic [31:0] f_next_stable(int i);
        logic [31:0] r;
        r = m_stable[i];
        if (f_deb(i) == 0) begin
            r = m_hsync[i][0];
        end else begin
            for (int b = 0; b < 32; b++) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < f_deb(i); k++) begin
                    if (m_hsync[i][k][b] == m_stable[i][b]) all_diff = 1'b0;
                end
                if (all_diff) r[b] = m_hsync[i][0][b];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] f_ev(int i);
        logic [31:0] rise, fall;
        rise = m_stable[i] & ~m_prev[i];
        fall = ~m_stable[i] & m_prev[i];
        if (f_et(i) == 0) return rise;
        if (f_et(i) == 1) return fall;
        return rise | fall;
    endfunction

    function automatic logic [31:0] f_read(int i);
        case (address)
            2'd0:    return m_stable[i];
            2'd2:    return m_mask[i];
            2'd3:    return m_ecap[i];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 4; k++) m_hin[i][k] <= 32'd0;
                for (int k = 0; k < 8; k++) m_hsync[i][k] <= 32'd0;
                m_stable[i] <= 32'd0;
                m_prev[i]   <= 32'd0;
                m_ecap[i]   <= 32'd0;
                m_mask[i]   <= 32'd0;
                m_rd[i]     <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_rd[i]     <= f_read(i);
                m_prev[i]   <= m_stable[i];
                m_stable[i] <= f_next_stable(i);
                if (chipselect && !write_n && address == 2'd3)
                    m_ecap[i] <= (m_ecap[i] & ~(writedata & f_wm(i))) | f_ev(i);
                else
                    m_ecap[i] <= m_ecap[i] | f_ev(i);
                if (chipselect && !write_n && address == 2'd2)
                    m_mask[i] <= writedata & f_wm(i);
                m_hin[i][0] <= pin[i] & f_wm(i);
                for (int k = 1; k < 4; k++) m_hin[i][k] <= m_hin[i][k-1];
                m_hsync[i][0] <= m_hin[i][SYNC-2];
                for (int k = 1; k < 8; k++) m_hsync[i][k] <= m_hsync[i][k-1];
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_rd%0d", i), rd[i], m_rd[i]);
            check($sformatf("model_irq%0d", i), {31'd0, irqv[i]},
                  {31'd0, |(m_ecap[i] & m_mask[i])});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rdreg(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pin[i] = 32'd0;
        #1 reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        check("reset_rd_a", rd[0], 32'd0);
        check("reset_irq_a", {31'd0, irqv[0]}, 32'd0);

        // Rising edge on bit0 of A, no debounce.
        address = 2'd0;
        pin[0] = 32'd1;
        cyc(3);
        check("a_data_early", rd[0], 32'd0);
        cyc(1);
        check("a_data", rd[0], 32'd1);
        rdreg(2'd3);
        check("a_ecap", rd[0], 32'd1);
        check("a_irq_unmasked", {31'd0, irqv[0]}, 32'd0);

        // Mask behaviour.
        wr(2'd2, 32'd2);
        check("a_irq_mask10", {31'd0, irqv[0]}, 32'd0);
        wr(2'd2, 32'd3);
        check("a_irq_mask11", {31'd0, irqv[0]}, 32'd1);
        wr(2'd3, 32'd1);
        check("a_irq_cleared", {31'd0, irqv[0]}, 32'd0);

        // Clear coincident with a new rising edge: the event wins.
        pin[0] = 32'd0;
        cyc(6);
        pin[0] = 32'd1;
        cyc(5);
        check("a_irq_rise2", {31'd0, irqv[0]}, 32'd1);
        pin[0] = 32'd0;
        cyc(6);
        pin[0] = 32'd1;
        cyc(3);
        wr(2'd3, 32'd1);
        check("a_irq_setwins", {31'd0, irqv[0]}, 32'd1);
        rdreg(2'd3);
        check("a_ecap_setwins", rd[0], 32'd1);
        wr(2'd3, 32'd3);
        check("a_irq_final_clear", {31'd0, irqv[0]}, 32'd0);

        // B: 3-cycle glitch is rejected by the debouncer.
        address = 2'd0;
        pin[1] = 32'd2;
        cyc(3);
        pin[1] = 32'd0;
        cyc(10);
        check("b_glitch_irq", {31'd0, irqv[1]}, 32'd0);
        check("b_glitch_data", rd[1], 32'd0);
        rdreg(2'd3);
        check("b_glitch_ecap", rd[1], 32'd0);

        // B: 8-cycle pulse is accepted after sync + debounce delay.
        rdreg(2'd0);
        pin[1] = 32'd2;
        cyc(6);
        check("b_pulse_early", rd[1], 32'd0);
        check("b_pulse_irq_early", {31'd0, irqv[1]}, 32'd0);
        cyc(1);
        check("b_pulse_data", rd[1], 32'd2);
        check("b_pulse_irq", {31'd0, irqv[1]}, 32'd1);
        cyc(1);
        pin[1] = 32'd0;
        cyc(8);

        // C: 32-bit, any-edge capture on bit31 plus bit0.
        pin[2] = 32'h8000_0001;
        cyc(5);
        rdreg(2'd3);
        check("c_ecap_rise", rd[2], 32'h8000_0001);
        wr(2'd3, 32'h8000_0000);
        rdreg(2'd3);
        check("c_ecap_clr31", rd[2], 32'h0000_0001);
        pin[2] = 32'h0000_0001;
        cyc(5);
        rdreg(2'd3);
        check("c_ecap_fall", rd[2], 32'h8000_0001);
        wr(2'd0, 32'hFFFF_FFFF);
        rdreg(2'd0);
        check("c_data_wr_ignored", rd[2], 32'h0000_0001);
        wr(2'd1, 32'hFFFF_FFFF);
        rdreg(2'd1);
        check("c_rsvd", rd[2], 32'd0);
        wr(2'd2, 32'hFFFF_FFFF);
        rdreg(2'd2);
        check("a_mask_zero_ext", rd[0], 32'd3);
        check("c_mask_full", rd[2], 32'hFFFF_FFFF);

        // Reset in the middle of activity.
        pin[0] = 32'd2;
        pin[1] = 32'd1;
        cyc(2);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) pin[i] = 32'd0;
        @(negedge clk);
        check("rst_rd_c", rd[2], 32'd0);
        check("rst_irq_c", {31'd0, irqv[2]}, 32'd0);
        cyc(1);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rdreg(a[1:0]);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("post_rst_i%0d_a%0d", i, a), rd[i], 32'd0);
            end
        end

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
